// File: rtl/load_store_unit.sv
// Load/store unit between a requester and a single-port word memory.
// Byte/halfword loads are extracted and extended; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, RMW_WRITE, STORE, RESP} state_t;

    state_t      state;
    logic [1:0]  cap_lane;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [15:0] cap_wdata;
    logic        req_err;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   extract = {{24{sh[7] & ~uns}}, sh[7:0]};
            2'b01:   extract = {{16{sh[15] & ~uns}}, sh[15:0]};
            default: extract = word;
        endcase
    endfunction

    // Halfword lanes are always even here, so a byte-granular shift covers both sizes.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [1:0] size, input logic [15:0] data);
        logic [31:0] mask;
        logic [31:0] ins;
        case (size)
            2'b00:   mask = 32'h0000_00FF << {lane, 3'b000};
            2'b01:   mask = 32'h0000_FFFF << {lane, 3'b000};
            default: mask = 32'h0000_0000;
        endcase
        ins = {16'h0000, data} << {lane, 3'b000};
        merge = (word & ~mask) | (ins & mask);
    endfunction

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_addr >= ADDR_LIMIT) req_err = 1'b1;
    end

    // mem_wdata doubles as the merge buffer during read-modify-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= 32'h0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            cap_lane     <= 2'b00;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_wdata    <= 16'h0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready    <= 1'b0;
                        cap_lane     <= req_addr[1:0];
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_wdata    <= req_wdata[15:0];
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (!req_write) begin
                            state    <= LOAD;
                            mem_read <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end else if (req_size == 2'b10) begin
                            state     <= STORE;
                            mem_write <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= RMW_READ;
                            mem_read <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                LOAD: begin
                    state      <= RESP;
                    mem_read   <= 1'b0;
                    mem_addr   <= 32'h0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= extract(mem_rdata, cap_lane, cap_size, cap_unsigned);
                end
                RMW_READ: begin
                    state     <= RMW_WRITE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_wdata <= merge(mem_rdata, cap_lane, cap_size, cap_wdata);
                end
                RMW_WRITE, STORE: begin
                    state      <= RESP;
                    mem_write  <= 1'b0;
                    mem_addr   <= 32'h0;
                    mem_wdata  <= 32'h0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory attached.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [64];
    int rd_cnt = 0;
    int wr_cnt = 0;
    int ovl_cnt = 0;
    int resp_cnt = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) begin
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (mem_read && mem_write) ovl_cnt++;
        if (resp_valid) resp_cnt++;
    end

    // Called at #1 after a rising edge with the unit idle; returns likewise.
    task automatic do_req(input string name, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL %s_ready got=%b want=1", name, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++; $display("FAIL %s_timeout got=no_resp want=resp_valid", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=10000", {req_ready, resp_valid, resp_err, mem_read, mem_write});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h want=0", resp_rdata, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store_byte_load();
        int lat; logic [31:0] rd; logic er; int wr0;
        wr0 = wr_cnt;
        do_req("sw08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, lat, rd, er);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'h0 || wr_cnt - wr0 != 1) begin
            failures++; $display("FAIL sw08 lat=%0d err=%b rdata=%h writes=%0d want 2/0/0/1", lat, er, rd, wr_cnt - wr0);
        end
        checks++;
        if (mem[2] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL sw08_mem got=%h want=deadbeef", mem[2]);
        end
        do_req("lb09", 1'b0, 2'b00, 1'b0, 32'h09, 32'h0, lat, rd, er);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'hFFFFFFBE) begin
            failures++; $display("FAIL lb09 lat=%0d err=%b rdata=%h want 2/0/ffffffbe", lat, er, rd);
        end
        do_req("lbu0b", 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, lat, rd, er);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'h000000DE) begin
            failures++; $display("FAIL lbu0b lat=%0d err=%b rdata=%h want 2/0/000000de", lat, er, rd);
        end
    endtask

    task automatic test_half_store();
        int lat; logic [31:0] rd; logic er; int rd0; int wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("sh0a", 1'b1, 2'b01, 1'b0, 32'h0A, 32'h00001234, lat, rd, er);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1) begin
            failures++; $display("FAIL sh0a lat=%0d err=%b reads=%0d writes=%0d want 3/0/1/1", lat, er, rd_cnt - rd0, wr_cnt - wr0);
        end
        checks++;
        if (last_waddr !== 32'h08 || last_wdata !== 32'h1234BEEF) begin
            failures++; $display("FAIL sh0a_write addr=%h data=%h want 00000008/1234beef", last_waddr, last_wdata);
        end
        do_req("lh0a", 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, lat, rd, er);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'h00001234) begin
            failures++; $display("FAIL lh0a lat=%0d err=%b rdata=%h want 2/0/00001234", lat, er, rd);
        end
    endtask

    task automatic test_byte_store();
        int lat; logic [31:0] rd; logic er;
        do_req("sb08", 1'b1, 2'b00, 1'b0, 32'h08, 32'hFFFFFF80, lat, rd, er);
        checks++;
        if (lat != 3 || mem[2] !== 32'h1234BE80) begin
            failures++; $display("FAIL sb08 lat=%0d mem=%h want 3/1234be80", lat, mem[2]);
        end
        do_req("lb08", 1'b0, 2'b00, 1'b0, 32'h08, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'hFFFFFF80) begin
            failures++; $display("FAIL lb08 err=%b rdata=%h want 0/ffffff80", er, rd);
        end
        do_req("lhu08", 1'b0, 2'b01, 1'b1, 32'h08, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0000BE80) begin
            failures++; $display("FAIL lhu08 err=%b rdata=%h want 0/0000be80", er, rd);
        end
    endtask

    task automatic test_errors();
        logic        wv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sv [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
        logic [31:0] av [4] = '{32'h06, 32'h03, 32'h100, 32'h00};
        int lat; logic [31:0] rd; logic er; int rd0; int wr0;
        for (int i = 0; i < 4; i++) begin
            rd0 = rd_cnt; wr0 = wr_cnt;
            do_req("err", wv[i], sv[i], 1'b0, av[i], 32'hFFFFFFFF, lat, rd, er);
            checks++;
            if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || rd_cnt != rd0 || wr_cnt != wr0) begin
                failures++;
                $display("FAIL err_%0d lat=%0d err=%b rdata=%h strobes=%0d want 1/1/0/0", i, lat, er, rd, (rd_cnt - rd0) + (wr_cnt - wr0));
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            failures++; $display("FAIL err_hold err=%b rdata=%h want 1/0", resp_err, resp_rdata);
        end
        do_req("lbu_ff", 1'b0, 2'b00, 1'b1, 32'hFF, 32'h0, lat, rd, er);
        checks++;
        if (lat != 2 || er !== 1'b0) begin
            failures++; $display("FAIL lbu_ff lat=%0d err=%b want 2/0", lat, er);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er; int wr0; int resp0;
        do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, lat, rd, er);
        wr0 = wr_cnt; resp0 = resp_cnt;
        req_write = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_read !== 1'b1) begin
            failures++; $display("FAIL rst_rmw_read got=%b want=1", mem_read);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            failures++; $display("FAIL rst_mid ready=%b rd=%b wr=%b want 1/0/0", req_ready, mem_read, mem_write);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || mem_write !== 1'b0) begin
            failures++; $display("FAIL rst_held ready=%b wr=%b want 1/0", req_ready, mem_write);
        end
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != wr0 || resp_cnt != resp0 || mem[4] !== 32'hCAFEF00D) begin
            failures++; $display("FAIL rst_abort writes=%0d resps=%0d mem=%h want 0/0/cafef00d", wr_cnt - wr0, resp_cnt - resp0, mem[4]);
        end
        do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'hCAFEF00D) begin
            failures++; $display("FAIL rst_after lat=%0d err=%b rdata=%h want 2/0/cafef00d", lat, er, rd);
        end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int n = 0;
        int nresp = 0;
        int rd0; int ovl0;
        int i = 0;
        rd0 = rd_cnt; ovl0 = ovl_cnt;
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        while (nresp < 3 && i < 30) begin
            if (resp_valid) nresp++;
            if (req_valid && req_ready && n < 3) begin
                acc[n] = i;
                n++;
            end
            @(posedge clk); #1;
            if (n == 3) req_valid = 1'b0;
            i++;
        end
        req_valid = 1'b0;
        checks++;
        if (n != 3 || nresp != 3) begin
            failures++; $display("FAIL b2b_count accepts=%0d resps=%0d want 3/3", n, nresp);
        end
        checks++;
        if (n == 3 && (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3)) begin
            failures++; $display("FAIL b2b_spacing gaps=%0d,%0d want 3,3", acc[1] - acc[0], acc[2] - acc[1]);
        end
        checks++;
        if (rd_cnt - rd0 != 3 || ovl_cnt != ovl0 || resp_rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL b2b_strobes reads=%0d overlaps=%0d rdata=%h want 3/0/cafef00d", rd_cnt - rd0, ovl_cnt - ovl0, resp_rdata);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_word_store_byte_load();
        test_half_store();
        test_byte_store();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (ovl_cnt != 0) begin
            failures++; $display("FAIL strobe_overlap got=%0d want=0", ovl_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the attached data memory; legal byte addresses are 0 to 4*MEM_WORDS-1.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1: request present.
REQ-005 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-006 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1: request rejected; qualified by resp_valid.
REQ-014 SHALL have port mem_read, output, 1: memory read strobe.
REQ-015 SHALL have port mem_write, output, 1: memory write strobe; memory writes on the rising edge while high.
REQ-016 SHALL have port mem_addr, output, 32: word-aligned address, bits [1:0] = 00.
REQ-017 SHALL have port mem_wdata, output, 32: full word to write.
REQ-018 SHALL have port mem_rdata, input, 32: combinational read data, valid in the same cycle as mem_read.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD, RMW_READ, RMW_WRITE, STORE and RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, and all request fields are captured at that edge.
REQ-021 SHALL flag an error when req_size=11, when a halfword has addr[0]=1, when a word has addr[1:0]!=00, or when addr >= 4*MEM_WORDS.
REQ-022 On acceptance, SHALL transition IDLE->RESP when an error is flagged, IDLE->LOAD for a load, IDLE->STORE for a word store, and IDLE->RMW_READ for a byte or halfword store.
REQ-023 LOAD SHALL assert mem_read, capture the extracted mem_rdata, and transition to RESP.
REQ-024 RMW_READ SHALL assert mem_read, capture mem_rdata into a merge buffer, and transition to RMW_WRITE.
REQ-025 RMW_WRITE SHALL assert mem_write with the merged word, and transition to RESP.
REQ-026 STORE SHALL assert mem_write with mem_wdata=req_wdata, and transition to RESP.
REQ-027 RESP SHALL assert resp_valid for exactly one cycle and transition to IDLE; resp has no backpressure.
REQ-028 Load extraction SHALL use byte lane k=addr[1:0] to select bits [8k+7:8k], and halfword h=addr[1] to select bits [16h+15:16h]; the selected field SHALL be extended to 32 bits per req_unsigned.
REQ-029 Merge SHALL replace only the addressed byte with req_wdata[7:0], or the addressed halfword with req_wdata[15:0]; all other bits SHALL keep the value read.
REQ-030 mem_addr SHALL equal {captured_addr[31:2],2'b00} whenever a strobe is high, and SHALL be 0 otherwise.
REQ-031 mem_read and mem_write SHALL never be high in the same cycle, and an error request SHALL produce no strobe.
REQ-032 Latency from the acceptance edge to the resp_valid cycle SHALL be 1 cycle for an error, 2 for a load or word store, and 3 for a sub-word store.
REQ-033 resp_rdata and resp_err SHALL hold their values until the next resp_valid.
REQ-034 req_valid held high across back-to-back requests SHALL give one accept per completed transaction, with the next accept in the cycle after RESP.

Reset
REQ-035 reset=1 SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, and clear the merge buffer.
REQ-036 reset asserted mid-transaction SHALL abort it with no further strobe and no response; the first accept after reset deasserts SHALL proceed normally.

Verification
REQ-037 Bench SHALL check: store word 0xDEADBEEF at 0x08, then signed byte load at 0x09 -> resp_rdata=0xFFFFFFBE at T+2; unsigned byte load at 0x0B -> 0x000000DE.
REQ-038 Bench SHALL check: halfword store 0x00001234 at 0x0A over 0xDEADBEEF -> one mem_read, then one mem_write 0x1234BEEF to 0x08, resp at T+3; signed halfword load at 0x0A -> 0x00001234.
REQ-039 Bench SHALL check: byte store 0x80 at 0x08 -> word 0x1234BE80; signed byte load at 0x08 -> 0xFFFFFF80.
REQ-040 Bench SHALL check: word load at 0x06, halfword store at 0x03, and byte load at 0x100 -> resp_err=1 at T+1, resp_rdata=0, no strobes.
REQ-041 Bench SHALL check: reset pulsed during RMW_READ of a byte store at 0x10 -> no mem_write, word at 0x10 unchanged, req_ready=1 while reset is high.
REQ-042 Bench SHALL check: req_valid held high for 3 word loads -> accepts spaced 3 cycles apart, three resp_valid pulses, strobes never overlap.
